// File: rtl/ibuf_pkg.sv
// Shared defaults and strobe naming for the pad input-conditioning block.
package ibuf_pkg;

  localparam int WIDTH_DEF       = 4;
  localparam int BUS_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_DEF      = 2;

  // Bit positions of the programmer-bus strobes within pad_in.
  localparam int ALE   = 0;
  localparam int WRITE = 1;
  localparam int READ  = 2;
  localparam int SDA   = 3;

  // Capture-edge selector values.
  localparam int CAP_FALL = 0;
  localparam int CAP_RISE = 1;

  // Width of a counter that must reach filter-1; never narrower than one bit.
  function automatic int cnt_width(input int filter);
    return (filter > 1) ? $clog2(filter) : 1;
  endfunction

endpackage

// File: rtl/ibuf_bit.sv
// One strobe lane: synchronizer chain, stability filter and registered edge
// detector. Also reports, one cycle early, whether the selected edge is about
// to be registered so the top level can capture the bus on the same edge.
module ibuf_bit
  import ibuf_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   FILTER      = FILTER_DEF,
  parameter logic INIT        = 1'b0,
  parameter logic CAP_EN      = 1'b0,
  parameter logic CAP_RISE    = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic cap_o
);

  localparam int                CNT_W   = cnt_width(FILTER);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw pad through the synchronizer chain.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
  end

  // Filter decision: accept a new level only after FILTER disagreeing cycles.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s;
      cnt_d   = '0;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Register filter state and the one-cycle edge pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign cap_o   = CAP_EN & (CAP_RISE ? rise_d : fall_d);

endmodule

// File: rtl/ibuf.sv
// Pad input conditioning: re-times and deglitches WIDTH asynchronous strobes
// and latches the asynchronous bus on the selected edge of one strobe.
module ibuf
  import ibuf_pkg::*;
#(
  parameter int               WIDTH       = WIDTH_DEF,
  parameter int               BUS_W       = BUS_W_DEF,
  parameter int               SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int               FILTER      = FILTER_DEF,
  parameter logic [WIDTH-1:0] INIT        = '0,
  parameter int               CAP_BIT     = ALE,
  parameter int               CAP_EDGE    = CAP_FALL
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [BUS_W-1:0] pad_bus,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [BUS_W-1:0] bus_q,
  output logic             bus_valid
);

  // Bus delay matches strobe latency so the captured word is the one present
  // when the capturing strobe value was first sampled.
  localparam int DLY = SYNC_STAGES + FILTER - 1;

  logic [WIDTH-1:0] cap_nxt;
  logic             capture;
  logic [BUS_W-1:0] dly_q [DLY];
  logic [BUS_W-1:0] bus_data_q, bus_data_d;
  logic             valid_q, valid_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ibuf_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER      (FILTER),
      .INIT        (INIT[i]),
      .CAP_EN      (i == CAP_BIT),
      .CAP_RISE    (CAP_EDGE == CAP_RISE)
    ) u_bit (
      .clock   (clock),
      .reset_n (reset_n),
      .pad_i   (pad_in[i]),
      .level_o (level[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i]),
      .cap_o   (cap_nxt[i])
    );
  end

  // Only the selected lane can drive its capture flag high.
  assign capture = |cap_nxt;

  // Bus delay line, aligned with the strobe synchronizer plus filter.
  // NOTE: this array is a handful of flops, so it is reset like any register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DLY; k++) dly_q[k] <= '0;
    end else begin
      dly_q[0] <= pad_bus;
      for (int k = 1; k < DLY; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  // Load the delayed bus on the capturing edge, hold otherwise.
  always_comb begin
    bus_data_d = bus_data_q;
    valid_d    = capture;
    if (capture) bus_data_d = dly_q[DLY-1];
  end

  // Capture register and its one-cycle valid strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_data_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      bus_data_q <= bus_data_d;
      valid_q    <= valid_d;
    end
  end

  assign bus_q     = bus_data_q;
  assign bus_valid = valid_q;

endmodule

// File: tb/tb_ibuf.sv
// Bench for ibuf: directed scenarios plus random pad activity, checked by a
// scoreboard fed from a sample-history reference model.
module tb_ibuf;
  import ibuf_pkg::*;

  localparam int             W      = 4;
  localparam int             BW     = 8;
  localparam int             SS     = 2;
  localparam int             F      = 2;
  localparam logic [W-1:0]   INIT_V = '0;
  localparam int             HIST   = SS + F;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  pad_in  = '0;
  logic [BW-1:0] pad_bus = '0;
  logic [W-1:0]  level, rise, fall;
  logic [BW-1:0] bus_q;
  logic          bus_valid;

  ibuf #(
    .WIDTH(W), .BUS_W(BW), .SYNC_STAGES(SS), .FILTER(F),
    .INIT(INIT_V), .CAP_BIT(ALE), .CAP_EDGE(CAP_FALL)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pad_in(pad_in), .pad_bus(pad_bus),
    .level(level), .rise(rise), .fall(fall), .bus_q(bus_q), .bus_valid(bus_valid)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0]  level;
    logic [W-1:0]  rise;
    logic [W-1:0]  fall;
    logic [BW-1:0] bus;
    logic          bus_valid;
  } obs_t;

  obs_t          exp_q[$];
  logic [BW-1:0] bus_exp_q[$];
  logic [W-1:0]  m_pad[$];
  logic [BW-1:0] m_bus[$];
  logic [W-1:0]  m_level;
  logic [BW-1:0] m_busq;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.level = INIT_V;
    return o;
  endfunction

  // Model state: the last HIST edge samples of pad_in/pad_bus, zero after reset.
  task automatic model_reset();
    m_pad.delete();
    m_bus.delete();
    for (int k = 0; k < HIST; k++) begin
      m_pad.push_back('0);
      m_bus.push_back('0);
    end
    m_level = INIT_V;
    m_busq  = '0;
    bus_exp_q.delete();
  endtask

  // A lane changes level once the synchronized value (pad as sampled SS edges
  // earlier) has disagreed with it for F consecutive edges. The bus word
  // captured is the one sampled alongside the first disagreeing strobe sample.
  task automatic model_step();
    obs_t o;
    logic diff;
    o = '0;
    m_pad.push_back(pad_in);
    m_bus.push_back(pad_bus);
    void'(m_pad.pop_front());
    void'(m_bus.pop_front());
    for (int i = 0; i < W; i++) begin
      diff = 1'b1;
      for (int j = 0; j < F; j++)
        if (m_pad[HIST-1-SS-j][i] == m_level[i]) diff = 1'b0;
      if (diff) begin
        m_level[i] = ~m_level[i];
        o.rise[i]  = m_level[i];
        o.fall[i]  = ~m_level[i];
      end
    end
    if (o.fall[ALE]) begin
      m_busq      = m_bus[0];
      o.bus_valid = 1'b1;
      bus_exp_q.push_back(m_busq);
    end
    o.level = m_level;
    o.bus   = m_busq;
    exp_q.push_back(o);
  endtask

  // Model advances on every clock edge and predicts the post-edge outputs.
  always @(posedge clock) begin
    if (!reset_n) begin
      model_reset();
      exp_q.push_back(reset_obs());
    end else begin
      model_step();
    end
  end

  // Async reset clears outputs immediately, so pending predictions become reset values.
  always @(negedge reset_n) begin
    model_reset();
    foreach (exp_q[k]) exp_q[k] = reset_obs();
  end

  // Monitor: compare every cycle on the falling edge, and every bus capture.
  always @(negedge clock) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.level = level; a.rise = rise; a.fall = fall;
      a.bus = bus_q; a.bus_valid = bus_valid;
      check("outputs", a, e);
      check("rise_fall_exclusive", |(rise & fall), 0);
      if (bus_valid) begin
        if (bus_exp_q.size() == 0) check("bus_valid_unexpected", bus_valid, 0);
        else                       check("bus_capture", bus_q, bus_exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, rises, falls;
    logic found;
    model_reset();

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_level", level, INIT_V);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
    check("reset_bus_q", bus_q, 0);
    check("reset_bus_valid", bus_valid, 0);
    reset_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clock);
      pulses += $countones(rise | fall) + int'(bus_valid);
    end
    check("idle_no_pulses", pulses, 0);

    // Clean rising and falling edge on WRITE
    @(negedge clock) pad_in[WRITE] = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("rise_not_before_edge4", {level[WRITE], rise[WRITE]}, 2'b00);
    @(posedge clock);
    #1 check("rise_at_edge4", {level[WRITE], rise[WRITE]}, 2'b11);
    @(posedge clock);
    #1 check("rise_one_cycle", {level[WRITE], rise[WRITE]}, 2'b10);
    @(negedge clock) pad_in[WRITE] = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("fall_not_before_edge4", {level[WRITE], fall[WRITE]}, 2'b10);
    @(posedge clock);
    #1 check("fall_at_edge4", {level[WRITE], fall[WRITE]}, 2'b01);
    repeat (4) @(negedge clock);

    // Glitch reject: one cycle on READ is discarded
    pad_in[READ] = 1'b1;
    @(negedge clock) pad_in[READ] = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clock);
      pulses += int'(rise[READ]) + int'(fall[READ]) + int'(level[READ]);
    end
    check("glitch_rejected", pulses, 0);

    // Two-cycle pulse on READ passes
    pad_in[READ] = 1'b1;
    repeat (2) @(negedge clock);
    pad_in[READ] = 1'b0;
    rises = 0; falls = 0;
    repeat (10) begin
      @(negedge clock);
      rises += int'(rise[READ]);
      falls += int'(fall[READ]);
    end
    check("two_cycle_rise", rises, 1);
    check("two_cycle_fall", falls, 1);

    // Bus capture on falling ALE
    pad_bus = 8'h10;
    pad_in[ALE] = 1'b1;
    repeat (6) @(negedge clock);
    pad_in[ALE] = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 12 && !found; t++) begin
      @(negedge clock);
      if (bus_valid) found = 1'b1;
    end
    check("bus_valid_seen", found, 1);
    check("bus_valid_with_fall0", fall[ALE], 1);
    check("bus_q_value", bus_q, 8'h10);
    @(negedge clock);
    check("bus_valid_one_cycle", bus_valid, 0);
    pad_bus = 8'hA5;
    repeat (6) @(negedge clock);
    check("bus_q_held", bus_q, 8'h10);

    // Simultaneous edges on all lanes
    pad_in = 4'hF;
    found = 1'b0;
    for (int t = 0; t < 12 && !found; t++) begin
      @(negedge clock);
      if (rise != 0) found = 1'b1;
    end
    check("simul_rise", rise, 4'hF);
    pad_in = 4'h0;
    found = 1'b0;
    for (int t = 0; t < 12 && !found; t++) begin
      @(negedge clock);
      if (fall != 0) found = 1'b1;
    end
    check("simul_fall", fall, 4'hF);
    repeat (4) @(negedge clock);

    // Reset one cycle before a pending update on SDA
    pad_in[SDA] = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge clock);
      pulses += int'(rise[SDA]);
    end
    check("midfilter_no_pulse", pulses, 0);
    check("midfilter_level_init", level, INIT_V);
    reset_n = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 12 && !found; t++) begin
      @(negedge clock);
      if (rise[SDA]) found = 1'b1;
    end
    check("post_reset_update", found, 1);
    pad_in[SDA] = 1'b0;
    repeat (6) @(negedge clock);

    // Random pad and bus activity
    for (int n = 0; n < 800; n++) begin
      @(negedge clock);
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 3) == 0) pad_in[i] = ~pad_in[i];
      if ($urandom_range(0, 1) == 0) pad_bus = BW'($urandom);
      if (n == 400) begin
        @(posedge clock);
        #2 reset_n = 1'b0;
        @(negedge clock) reset_n = 1'b1;
      end
    end
    repeat (10) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
